// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, pipeline register types and width defaults
package alu_pkg;
  localparam int ALU_XLEN = 32;
  localparam int ALU_REGS_AW = 5;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } alu_op_e;
  typedef struct packed {
    logic                   valid;
    alu_op_e                op;
    logic [ALU_XLEN-1:0]    a;
    logic [ALU_XLEN-1:0]    b;
    logic [ALU_REGS_AW-1:0] rd;
    logic                   we;
  } ex_reg_t;
  typedef struct packed {
    logic                   valid;
    logic [ALU_REGS_AW-1:0] rd;
    logic                   we;
    logic [ALU_XLEN-1:0]    data;
  } wb_reg_t;
endpackage

// File: rtl/alu_fwd_sel.sv
// alu_fwd_sel: resolves one source operand against EX, WB and external writeback
module alu_fwd_sel
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int REGS_AW = ALU_REGS_AW
) (
  input  logic [REGS_AW-1:0] rs,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               ex_valid,
  input  logic               ex_we,
  input  logic [REGS_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]    ex_data,
  input  logic               wb_valid,
  input  logic               wb_we,
  input  logic [REGS_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ext_we,
  input  logic [REGS_AW-1:0] ext_rd,
  input  logic [XLEN-1:0]    ext_data,
  output logic [XLEN-1:0]    fwd_data,
  output logic               hazard
);
  logic nz, ex_hit, wb_hit, ext_hit;
  always_comb begin
    nz       = rs != '0;
    ex_hit   = nz && ex_valid && ex_we && ex_rd == rs;
    wb_hit   = nz && wb_valid && wb_we && wb_rd == rs;
    ext_hit  = nz && ext_we && ext_rd == rs;
    fwd_data = !nz ? '0 : ex_hit ? ex_data : wb_hit ? wb_data : ext_hit ? ext_data : rf_data;
    hazard   = ex_hit || wb_hit;
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand issue / result capture around an external ALU.
// ALU_ISSUE_FWD_EN builds the forwarding network; otherwise hazards interlock.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int REGS_AW = ALU_REGS_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [REGS_AW-1:0] in_rs1,
  input  logic [REGS_AW-1:0] in_rs2,
  input  logic [REGS_AW-1:0] in_rd,
  input  logic               in_rd_we,
  input  logic               in_use_imm,
  input  logic [XLEN-1:0]    in_imm,
  output logic [REGS_AW-1:0] rf_rs1_addr,
  output logic [REGS_AW-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]    rf_rs1_data,
  input  logic [XLEN-1:0]    rf_rs2_data,
  input  logic               wb_we,
  input  logic [REGS_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [3:0]         alu_op,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  input  logic [XLEN-1:0]    alu_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REGS_AW-1:0] out_rd,
  output logic               out_we,
  output logic [XLEN-1:0]    out_data,
  output logic [15:0]        stall_cnt
);
  ex_reg_t ex_q, ex_d;
  wb_reg_t wb_q, wb_d;
  logic [15:0] stall_q, stall_d;
  logic [XLEN-1:0] fwd1, fwd2, rs1_val, rs2_val, b_val;
  logic haz1, haz2, interlock, wb_adv, wb_load, xfer;

  alu_fwd_sel #(.XLEN(XLEN), .REGS_AW(REGS_AW)) u_fwd_rs1 (
    .rs(in_rs1), .rf_data(rf_rs1_data),
    .ex_valid(ex_q.valid), .ex_we(ex_q.we), .ex_rd(ex_q.rd), .ex_data(alu_y),
    .wb_valid(wb_q.valid), .wb_we(wb_q.we), .wb_rd(wb_q.rd), .wb_data(wb_q.data),
    .ext_we(wb_we), .ext_rd(wb_rd), .ext_data(wb_data),
    .fwd_data(fwd1), .hazard(haz1)
  );

  alu_fwd_sel #(.XLEN(XLEN), .REGS_AW(REGS_AW)) u_fwd_rs2 (
    .rs(in_rs2), .rf_data(rf_rs2_data),
    .ex_valid(ex_q.valid), .ex_we(ex_q.we), .ex_rd(ex_q.rd), .ex_data(alu_y),
    .wb_valid(wb_q.valid), .wb_we(wb_q.we), .wb_rd(wb_q.rd), .wb_data(wb_q.data),
    .ext_we(wb_we), .ext_rd(wb_rd), .ext_data(wb_data),
    .fwd_data(fwd2), .hazard(haz2)
  );

`ifdef ALU_ISSUE_FWD_EN
  logic unused_haz;
  assign unused_haz = haz1 | haz2;
  assign rs1_val    = fwd1;
  assign rs2_val    = fwd2;
  assign interlock  = 1'b0;
`else
  // The external writeback is assumed to land in the RF before the read, so only EX/WB stall.
  logic unused_fwd;
  assign unused_fwd = ^{fwd1, fwd2};
  assign rs1_val    = in_rs1 == '0 ? '0 : rf_rs1_data;
  assign rs2_val    = in_rs2 == '0 ? '0 : rf_rs2_data;
  assign interlock  = haz1 || (!in_use_imm && haz2);
`endif

  always_comb begin
    wb_adv     = ex_q.valid && (!wb_q.valid || out_ready);
    in_ready   = !flush && (!ex_q.valid || wb_adv) && !interlock;
    xfer       = in_valid && in_ready;
    wb_load    = wb_adv && !flush;
    b_val      = in_use_imm ? in_imm : rs2_val;
    ex_d       = xfer ? '{valid: 1'b1, op: alu_op_e'(in_op), a: rs1_val, b: b_val, rd: in_rd, we: in_rd_we} : ex_q;
    ex_d.valid = xfer || (ex_q.valid && !flush && !wb_adv);
    wb_d       = wb_load ? '{valid: 1'b1, rd: ex_q.rd, we: ex_q.we, data: alu_y} : wb_q;
    wb_d.valid = wb_load || (wb_q.valid && !out_ready);
    stall_d    = (in_valid && !in_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      wb_q    <= '0;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
    end
  end

  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;
  assign alu_op      = ex_q.op;
  assign alu_a       = ex_q.a;
  assign alu_b       = ex_q.b;
  assign out_valid   = wb_q.valid;
  assign out_rd      = wb_q.rd;
  assign out_we      = wb_q.we;
  assign out_data    = wb_q.data;
  assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with an architectural register model.
// Expected stall counts follow ALU_ISSUE_FWD_EN.
module tb_alu_issue;
  import alu_pkg::*;
  localparam int XLEN = 32;
  localparam int AW   = 5;
`ifdef ALU_ISSUE_FWD_EN
  localparam int RAW_WAIT   = 0;
  localparam int CHAIN_WAIT = 0;
`else
  localparam int RAW_WAIT   = 2;
  localparam int CHAIN_WAIT = 8;
`endif

  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_rd_we = 0, in_use_imm = 0;
  logic wb_we = 0, out_ready = 1;
  logic [3:0] in_op = '0;
  logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0;
  logic [XLEN-1:0] in_imm = '0, wb_data = '0;
  logic in_ready, out_valid, out_we;
  logic [AW-1:0] rf_rs1_addr, rf_rs2_addr, out_rd;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data, alu_a, alu_b, alu_y, out_data;
  logic [3:0] alu_op;
  logic [15:0] stall_cnt;

  logic [XLEN-1:0] rf   [32] = '{default: 32'hBAD0_0000};
  logic [XLEN-1:0] arch [32] = '{default: 32'hBAD0_0000};
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic            we;
    logic [XLEN-1:0] data;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, exp_stall = 0;

  alu_issue #(.XLEN(XLEN), .REGS_AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_we(out_we),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      4'd0: alu_f = a + b;
      4'd1: alu_f = a - b;
      4'd2: alu_f = a & b;
      4'd3: alu_f = a | b;
      4'd4: alu_f = a ^ b;
      4'd5: alu_f = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd6: alu_f = {{(XLEN-1){1'b0}}, a < b};
      4'd7: alu_f = a << b[4:0];
      4'd8: alu_f = a >> b[4:0];
      4'd9: alu_f = $signed(a) >>> b[4:0];
      default: alu_f = '0;
    endcase
  endfunction

  // External ALU and a write-through register file
  assign alu_y = alu_f(alu_op, alu_a, alu_b);
  assign rf_rs1_data = (wb_we && wb_rd == rf_rs1_addr && rf_rs1_addr != 0) ? wb_data : rf[rf_rs1_addr];
  assign rf_rs2_data = (wb_we && wb_rd == rf_rs2_addr && rf_rs2_addr != 0) ? wb_data : rf[rf_rs2_addr];

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && out_we && out_rd != 0) rf[out_rd] <= out_data;
    if (wb_we && wb_rd != 0) rf[wb_rd] <= wb_data;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got rd=%0d we=%0b data=%h, required no retire", out_rd, out_we, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_rd, out_we, out_data} !== {e.rd, e.we, e.data}) begin
          errors++;
          $display("FAIL retire: got rd=%0d we=%0b data=%h, required rd=%0d we=%0b data=%h",
                   out_rd, out_we, out_data, e.rd, e.we, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [AW-1:0] r, input logic [XLEN-1:0] v);
    wb_we = 1; wb_rd = r; wb_data = v;
    @(posedge clk); #1;
    wb_we = 0;
    arch[r] = v;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic we, input logic use_imm,
                       input logic [XLEN-1:0] imm, output int waited);
    logic [XLEN-1:0] a, b, y;
    in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_we = we; in_use_imm = use_imm; in_imm = imm;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready=0 after %0d cycles, required 1", waited);
      in_valid = 0;
      return;
    end
    a = rs1 == 0 ? '0 : arch[rs1];
    b = use_imm ? imm : (rs2 == 0 ? '0 : arch[rs2]);
    y = alu_f(op, a, b);
    sb.push_back(exp_t'{rd, we, y});
    if (we && rd != 0) arch[rd] = y;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if ({alu_op, alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu: got op=%h a=%h b=%h required 0", alu_op, alu_a, alu_b); end
    checks++; if ({out_rd, out_we, out_data} !== '0) begin errors++; $display("FAIL reset_out: got rd=%0d we=%b data=%h required 0", out_rd, out_we, out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d required 0", stall_cnt); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w;
    preload(1, 5); preload(2, 7);
    issue(ADD, 1, 2, 3, 1, 0, 0, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL basic_wait: got %0d required 0", w); end
    checks++; if ({alu_op, alu_a, alu_b} !== {4'd0, 32'd5, 32'd7}) begin errors++; $display("FAIL basic_ex: got op=%0d a=%0d b=%0d required 0/5/7", alu_op, alu_a, alu_b); end
    @(posedge clk); #1;
    checks++; if ({out_valid, out_rd, out_data} !== {1'b1, 5'd3, 32'd12}) begin errors++; $display("FAIL basic_wb: got v=%b rd=%0d data=%0d required 1/3/12", out_valid, out_rd, out_data); end
    drain();
  endtask

  task automatic test_raw();
    int w1, w2;
    preload(1, 99); preload(2, 10); preload(3, 4); preload(5, 1);
    issue(ADD, 2, 3, 1, 1, 0, 0, w1);
    issue(SUB, 1, 5, 4, 1, 0, 0, w2);
    checks++; if (w2 !== RAW_WAIT) begin errors++; $display("FAIL raw_wait: got %0d required %0d", w2, RAW_WAIT); end
    checks++; if (alu_a !== 32'd14) begin errors++; $display("FAIL raw_alu_a: got %0d required 14", alu_a); end
    exp_stall += RAW_WAIT;
    drain();
    checks++; if (stall_cnt !== exp_stall[15:0]) begin errors++; $display("FAIL raw_stall_cnt: got %0d required %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_back_to_back();
    int w, total;
    total = 0;
    issue(ADD, 2, 0, 12, 1, 1, 32'd5, w); total += w;
    issue(SUB, 3, 12, 13, 1, 0, 0, w); total += w;
    issue(SLT, 13, 12, 14, 1, 0, 0, w); total += w;
    issue(SRA, 13, 5, 15, 1, 0, 0, w); total += w;
    issue(ADD, 0, 15, 16, 1, 1, 32'd1, w); total += w;
    issue(ADD, 16, 0, 16, 1, 1, 32'd1, w); total += w;
    issue(ADD, 16, 16, 17, 1, 0, 0, w); total += w;
    checks++; if (alu_a !== 32'd2 || alu_b !== 32'd2) begin errors++; $display("FAIL b2b_priority: got a=%0d b=%0d required 2/2", alu_a, alu_b); end
    issue(ADD, 2, 2, 21, 0, 0, 0, w); total += w;
    issue(ADD, 21, 2, 22, 1, 0, 0, w); total += w;
    checks++; if (total !== CHAIN_WAIT) begin errors++; $display("FAIL b2b_waits: got %0d required %0d", total, CHAIN_WAIT); end
    exp_stall += CHAIN_WAIT;
    drain();
    checks++; if (stall_cnt !== exp_stall[15:0]) begin errors++; $display("FAIL b2b_stall_cnt: got %0d required %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 0;
    issue(ADD, 2, 3, 7, 1, 0, 0, w);
    issue(XOR, 5, 0, 8, 1, 1, 32'hF0, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL bp_second_wait: got %0d required 0", w); end
    in_valid = 1; in_op = OR; in_rs1 = 2; in_rs2 = 5; in_rd = 9; in_rd_we = 1; in_use_imm = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      checks++; if ({out_valid, out_rd, out_data} !== {1'b1, 5'd7, 32'd14}) begin errors++; $display("FAIL bp_wb_hold: got v=%b rd=%0d data=%0d required 1/7/14", out_valid, out_rd, out_data); end
      @(posedge clk); #1;
    end
    out_ready = 1;
    issue(OR, 2, 5, 9, 1, 0, 0, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL bp_release_wait: got %0d required 0", w); end
    exp_stall += 2;
    drain();
    checks++; if (stall_cnt !== exp_stall[15:0]) begin errors++; $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_x0();
    int w;
    issue(ADD, 2, 3, 0, 1, 0, 0, w);
    issue(ADD, 0, 2, 10, 1, 0, 0, w);
    checks++; if (w !== 0 || alu_a !== '0 || alu_b !== 32'd10) begin errors++; $display("FAIL x0_ex: got wait=%0d a=%h b=%0d required 0/0/10", w, alu_a, alu_b); end
    wb_we = 1; wb_rd = 0; wb_data = 32'hDEAD;
    issue(ADD, 0, 0, 11, 1, 0, 0, w);
    checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL x0_ext: got a=%h b=%h required 0/0", alu_a, alu_b); end
    wb_rd = 20; wb_data = 32'h1234; arch[20] = 32'h1234;
    issue(ADD, 20, 0, 18, 1, 0, 0, w);
    wb_we = 0;
    checks++; if (alu_a !== 32'h1234) begin errors++; $display("FAIL ext_fwd: got a=%h required 1234", alu_a); end
    drain();
  endtask

  task automatic test_flush();
    int w;
    logic [XLEN-1:0] saved6;
    out_ready = 0;
    issue(ADD, 2, 3, 5, 1, 0, 0, w);
    saved6 = arch[6];
    issue(XOR, 2, 3, 6, 1, 0, 0, w);
    void'(sb.pop_back());
    arch[6] = saved6;
    flush = 1; out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
    checks++; if ({out_valid, out_rd} !== {1'b1, 5'd5}) begin errors++; $display("FAIL flush_wb: got v=%b rd=%0d required 1/5", out_valid, out_rd); end
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_killed: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready); end
    repeat (2) @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 0;
    issue(ADD, 2, 3, 23, 1, 0, 0, w);
    issue(SUB, 2, 3, 24, 1, 0, 0, w);
    #2 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready); end
    checks++; if ({alu_op, alu_a, alu_b, out_rd, out_we, out_data} !== '0) begin errors++; $display("FAIL rst_mid_regs: got op=%h a=%h b=%h rd=%0d we=%b data=%h required 0", alu_op, alu_a, alu_b, out_rd, out_we, out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_stall: got %0d required 0", stall_cnt); end
    sb.delete();
    arch = rf;
    exp_stall = 0;
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    @(posedge clk); #1;
    issue(ADD, 2, 5, 25, 1, 0, 0, w);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_x0();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_queue: %0d outstanding, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
